alu_iter_divider: RTL and testbench
===================================

// Module: alu_iter_divider
// PURPOSE
//  Multi-cycle integer divide unit for the RV32 execute stage, placed beside the single-cycle alu.
//  Answers the RV32M DIV/DIVU/REM/REMU ops over a valid/ready request-response handshake.
//  Radix-2 restoring divider, one quotient bit per cycle.
//  Flag outputs use the same meaning as the alu flags.
// PARAMETERS
//  XLEN      32   operand/result width; must be >= 4
//  CNT_W     6    iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  req_valid      in   1      request present
//  req_ready      out  1      unit can accept a request (1 only in IDLE)
//  operand_a      in   XLEN   dividend
//  operand_b      in   XLEN   divisor
//  div_op         in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//  rsp_valid      out  1      result/flags valid
//  rsp_ready      in   1      consumer takes result
//  result         out  XLEN   quotient (DIV/DIVU) or remainder (REM/REMU)
//  zero_flag      out  1      result == 0
//  sign_flag      out  1      result[XLEN-1]
//  overflow_flag  out  1      signed overflow case (DIV/REM, a = -2**(XLEN-1), b = -1)
//  dbz_flag       out  1      divisor == 0
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; result and all flags = 0.
//   rst_n low at any time, including mid-CALC or DONE, aborts the operation.
//   An aborted operation never produces a response.
//  FSM:
//   - IDLE -> CALC on req_valid & req_ready.
//     Capture |a|, |b|, op, quotient sign (a^b), remainder sign (a).
//     Signed ops only; unsigned ops use raw operands. Clear counter and partial remainder.
//   - CALC: one restoring step per cycle, for exactly XLEN cycles.
//     Shift {rem,quo} left 1. Trial subtract b.
//     If no borrow: keep the difference and set quo[0]=1.
//   - CALC -> DONE after the XLEN-th step. Apply sign fix-up and register result/flags.
//     Result registers are valid in DONE.
//   - DONE: rsp_valid=1. result and flags stay stable while rsp_ready=0.
//     DONE -> IDLE on rsp_ready. rsp_valid drops the next cycle.
//  Latency: accept edge + XLEN CALC cycles + 1. rsp_valid rises XLEN+1 cycles after the accept edge.
//   Throughput is 1 op per XLEN+2 cycles minimum. There is no overlap: req_ready=0 outside IDLE.
//  Arithmetic (RISC-V M semantics):
//   - Signed magnitudes use two's-complement negate. |-2**(XLEN-1)| wraps to the same bit pattern; treat it as unsigned.
//   - Signed ops: quotient negated if signs differ; remainder takes the dividend sign.
//   - b=0: quotient = all ones; remainder = a; dbz_flag=1. Applies to signed and unsigned.
//   - Signed overflow: quotient = -2**(XLEN-1); remainder = 0; overflow_flag=1.
//   - zero_flag and sign_flag are computed from the final selected result.
//  Inputs are sampled only on the accept edge. Changes in operand_a, operand_b or div_op afterwards are ignored.
//  req_valid asserted outside IDLE is ignored (not queued).
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//   - b=0 or signed-overflow requests go IDLE -> DONE directly.
//   - rsp_valid rises 1 cycle after the accept edge, with the same values and flags as below.
//  DIV_EARLY_OUT_EN undefined:
//   - Every request takes the full XLEN+1 cycle latency.
//   - Special-case values come from the datapath plus fix-up.
// TESTING
//  1 DIVU a=0x00000064, b=0x00000007, rsp_ready=1.
//    -> result=0x0000000E, all flags 0; rsp_valid exactly 33 cycles after accept.
//  2 REM a=0xFFFFFFF9 (-7), b=0x00000002 -> result=0xFFFFFFFF, sign_flag=1.
//    DIV on the same operands -> 0xFFFFFFFD.
//  3 DIV a=0x12345678, b=0 -> result=0xFFFFFFFF, dbz_flag=1.
//    REMU a=0x12345678, b=0 -> 0x12345678.
//    Latency is 1 with DIV_EARLY_OUT_EN, 33 without.
//  4 DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, overflow_flag=1.
//    REM on the same operands -> 0x00000000, zero_flag=1.
//  5 Backpressure: DIVU 10/3 with rsp_ready=0 for 5 cycles after rsp_valid.
//    -> result=0x00000003 stable and req_ready=0 throughout.
//    Raise rsp_ready -> IDLE next cycle; new request accepted immediately.
//  6 Reset mid-op: pull rst_n low at CALC cycle 10 of DIVU 100/7.
//    -> all outputs reset, rsp_valid never asserts for it.
//    A subsequent DIVU 9/3 returns 0x00000003.

Source files
------------

// File: rtl/alu_iter_divider_if.sv
// Request/response bundle for the iterative divide unit.
// master = requester (execute stage), slave = divider.
interface alu_iter_divider_if #(
  parameter int XLEN = 32
);
  // Both channels use plain valid/ready: a transfer happens on a rising clock
  // edge where valid and ready are both 1. The source holds its payload
  // steady while valid=1 and ready=0.
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [1:0]      div_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] result;
  logic            zero_flag;
  logic            sign_flag;
  logic            overflow_flag;
  logic            dbz_flag;

  modport master (
    output req_valid, operand_a, operand_b, div_op, rsp_ready,
    input  req_ready, rsp_valid, result, zero_flag, sign_flag,
           overflow_flag, dbz_flag
  );

  modport slave (
    input  req_valid, operand_a, operand_b, div_op, rsp_ready,
    output req_ready, rsp_valid, result, zero_flag, sign_flag,
           overflow_flag, dbz_flag
  );
endinterface

// File: rtl/alu_iter_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC.
module alu_iter_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_iter_divider_if.slave  div_if,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              sel_rem_q, sel_rem_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              sign_q, sign_d;
  logic              ovf_flag_q, ovf_flag_d;
  logic              dbz_flag_q, dbz_flag_d;

  logic              in_signed, a_neg, b_neg, in_dbz, in_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     rem_sh;
  logic              no_borrow;
  logic [XLEN-1:0]   diff, step_rem, step_quo;
  logic              fin_load, fin_dbz, fin_ovf;
  logic [XLEN-1:0]   fin_value;

  // Special cases are forced last so they win over the generic sign fix-up.
  function automatic logic [XLEN-1:0] fix_result(
    input logic [XLEN-1:0] quo,
    input logic [XLEN-1:0] rem,
    input logic            sel_rem,
    input logic            qneg,
    input logic            rneg,
    input logic            dbz,
    input logic            ovf
  );
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    q = qneg ? -quo : quo;
    r = rneg ? -rem : rem;
    if (dbz) q = '1;
    if (ovf) begin
      q = MIN_NEG;
      r = '0;
    end
    return sel_rem ? r : q;
  endfunction

  // Signed magnitudes; |MIN_NEG| wraps to itself and is then read as unsigned.
  assign in_signed = ~div_if.div_op[0];
  assign a_neg     = in_signed & div_if.operand_a[XLEN-1];
  assign b_neg     = in_signed & div_if.operand_b[XLEN-1];
  assign a_mag     = a_neg ? -div_if.operand_a : div_if.operand_a;
  assign b_mag     = b_neg ? -div_if.operand_b : div_if.operand_b;
  assign in_dbz    = (div_if.operand_b == '0);
  assign in_ovf    = in_signed & (div_if.operand_a == MIN_NEG) & (div_if.operand_b == '1);

  // Shifted partial remainder needs XLEN+1 bits; after a successful subtract it fits XLEN.
  assign rem_sh    = {rem_q, quo_q[XLEN-1]};
  assign no_borrow = (rem_sh >= {1'b0, dvs_q});
  assign diff      = rem_sh[XLEN-1:0] - dvs_q;
  assign step_rem  = no_borrow ? diff : rem_sh[XLEN-1:0];
  assign step_quo  = {quo_q[XLEN-2:0], no_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      sel_rem_q  <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      sign_q     <= 1'b0;
      ovf_flag_q <= 1'b0;
      dbz_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      sel_rem_q  <= sel_rem_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      sign_q     <= sign_d;
      ovf_flag_q <= ovf_flag_d;
      dbz_flag_q <= dbz_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    sel_rem_d  = sel_rem_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    zero_d     = zero_q;
    sign_d     = sign_q;
    ovf_flag_d = ovf_flag_q;
    dbz_flag_d = dbz_flag_q;
    fin_load   = 1'b0;
    fin_value  = '0;
    fin_dbz    = 1'b0;
    fin_ovf    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (div_if.req_valid) begin
          sel_rem_d = div_if.div_op[1];
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          dbz_d     = in_dbz;
          ovf_d     = in_ovf;
          rem_d     = '0;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          cnt_d     = '0;
          state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
          if (in_dbz || in_ovf) begin
            fin_load  = 1'b1;
            fin_value = fix_result(a_mag, a_mag, div_if.div_op[1], a_neg ^ b_neg,
                                   a_neg, in_dbz, in_ovf);
            fin_dbz   = in_dbz;
            fin_ovf   = in_ovf;
            state_d   = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          fin_load  = 1'b1;
          fin_value = fix_result(step_quo, step_rem, sel_rem_q, qneg_q, rneg_q,
                                 dbz_q, ovf_q);
          fin_dbz   = dbz_q;
          fin_ovf   = ovf_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (div_if.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Result and flags only change when an operation completes.
    if (fin_load) begin
      result_d   = fin_value;
      zero_d     = (fin_value == '0);
      sign_d     = fin_value[XLEN-1];
      ovf_flag_d = fin_ovf;
      dbz_flag_d = fin_dbz;
    end
  end

  assign div_if.req_ready     = (state_q == S_IDLE);
  assign div_if.rsp_valid     = (state_q == S_DONE);
  assign div_if.result        = result_q;
  assign div_if.zero_flag     = zero_q;
  assign div_if.sign_flag     = sign_q;
  assign div_if.overflow_flag = ovf_flag_q;
  assign div_if.dbz_flag      = dbz_flag_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_alu_iter_divider.sv
// Directed-vector bench for alu_iter_divider: values, flags, latency,
// backpressure and mid-operation reset.
module tb_alu_iter_divider;

  localparam int XLEN = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam int LAT_FULL = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = XLEN + 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_err;
  logic [XLEN-1:0] exp_q[$];

  alu_iter_divider_if #(.XLEN(XLEN)) dif ();

  alu_iter_divider #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_if    (dif),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] flags_obs();
    return {28'd0, dif.zero_flag, dif.sign_flag, dif.overflow_flag, dif.dbz_flag};
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input string tag, input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b);
    @(negedge clk);
    check({tag, "_req_ready"}, XLEN'(dif.req_ready), 32'd1);
    dif.req_valid = 1'b1;
    dif.div_op    = op;
    dif.operand_a = a;
    dif.operand_b = b;
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge; the unit must ignore them.
    dif.req_valid = 1'b0;
    dif.operand_a = $urandom;
    dif.operand_b = $urandom;
    dif.div_op    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (dif.rsp_valid) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_r,
                        input logic [3:0] exp_f, input int exp_lat);
    int lat;
    logic [XLEN-1:0] e;
    dif.rsp_ready = 1'b1;
    exp_q.push_back(exp_r);
    issue(tag, op, a, b);
    wait_rsp(lat);
    check({tag, "_lat"}, XLEN'(lat), XLEN'(exp_lat));
    e = exp_q.pop_front();
    check({tag, "_result"}, dif.result, e);
    check({tag, "_flags"}, flags_obs(), {28'd0, exp_f});
    @(posedge clk);
    #1;
    check({tag, "_rsp_drop"}, XLEN'(dif.rsp_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int seen;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    dif.req_valid = 1'b0;
    dif.operand_a = '0;
    dif.operand_b = '0;
    dif.div_op    = '0;
    dif.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", XLEN'(dif.req_ready), 32'd1);
    check("rst_rsp_valid", XLEN'(dif.rsp_valid), 32'd0);
    check("rst_result", dif.result, 32'd0);
    check("rst_flags", flags_obs(), 32'd0);
    rst_n = 1'b1;

    // flags order: {zero, sign, overflow, dbz}
    run_op("divu_100_7",   OP_DIVU, 32'd100,      32'd7,        32'h0000000E, 4'b0000, LAT_FULL);
    run_op("rem_m7_2",     OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b0100, LAT_FULL);
    run_op("div_m7_2",     OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b0100, LAT_FULL);
    run_op("div_dbz",      OP_DIV,  32'h12345678, 32'd0,        32'hFFFFFFFF, 4'b0101, LAT_SPECIAL);
    run_op("remu_dbz",     OP_REMU, 32'h12345678, 32'd0,        32'h12345678, 4'b0001, LAT_SPECIAL);
    run_op("div_ovf",      OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0110, LAT_SPECIAL);
    run_op("rem_ovf",      OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1010, LAT_SPECIAL);
    run_op("remu_100_7",   OP_REMU, 32'd100,      32'd7,        32'h00000002, 4'b0000, LAT_FULL);
    run_op("div_7_m2",     OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 4'b0100, LAT_FULL);
    run_op("rem_7_m2",     OP_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, 4'b0000, LAT_FULL);
    run_op("div_m8_m2",    OP_DIV,  32'hFFFFFFF8, 32'hFFFFFFFE, 32'h00000004, 4'b0000, LAT_FULL);
    run_op("div_min_2",    OP_DIV,  32'h80000000, 32'd2,        32'hC0000000, 4'b0100, LAT_FULL);
    run_op("divu_max_1",   OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'b0100, LAT_FULL);
    run_op("divu_min_max", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000, LAT_FULL);
    run_op("rem_m5_dbz",   OP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 4'b0101, LAT_SPECIAL);
    run_op("div_m5_dbz",   OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 4'b0101, LAT_SPECIAL);
    run_op("remu_min_max", OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0100, LAT_FULL);

    // Backpressure: result held for 5 cycles, extra requests ignored.
    dif.rsp_ready = 1'b0;
    exp_q.push_back(32'd3);
    issue("bp", OP_DIVU, 32'd10, 32'd3);
    wait_rsp(lat);
    check("bp_lat", XLEN'(lat), XLEN'(LAT_FULL));
    for (int i = 0; i < 5; i++) begin
      check("bp_result", dif.result, exp_q[0]);
      check("bp_rsp_valid", XLEN'(dif.rsp_valid), 32'd1);
      check("bp_req_ready", XLEN'(dif.req_ready), 32'd0);
      dif.req_valid = 1'b1;
      dif.div_op    = OP_DIVU;
      dif.operand_a = 32'd50;
      dif.operand_b = 32'd5;
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    dif.req_valid = 1'b0;
    dif.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_rsp", XLEN'(dif.rsp_valid), 32'd0);
    check("bp_release_rdy", XLEN'(dif.req_ready), 32'd1);
    run_op("bp_next_9_3", OP_DIVU, 32'd9, 32'd3, 32'h00000003, 4'b0000, LAT_FULL);

    // Reset in the middle of a CALC sequence.
    issue("rst_mid", OP_DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    check("rst_mid_state_calc", XLEN'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_ready", XLEN'(dif.req_ready), 32'd1);
    check("rst_mid_rsp_valid", XLEN'(dif.rsp_valid), 32'd0);
    check("rst_mid_result", dif.result, 32'd0);
    check("rst_mid_flags", flags_obs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.rsp_valid) seen++;
    end
    check("rst_mid_no_rsp", XLEN'(seen), 32'd0);
    run_op("post_rst_9_3", OP_DIVU, 32'd9, 32'd3, 32'h00000003, 4'b0000, LAT_FULL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
